// File: rtl/calc_sequencer.sv
// Command sequencer for a shared arithmetic datapath: latches operands, starts the
// multiplier/ALU, waits a fixed number of cycles, captures and holds the result.
// Optional fast divide-by-zero path is enabled by defining CALC_SEQ_DIVZERO_EN.
module calc_sequencer #(
  parameter int MUL_CYCLES = 34,
  parameter int ALU_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [1:0]  op_sel,
  output logic [31:0] calc_a,
  output logic [31:0] calc_b,
  output logic [1:0]  calc_select,
  output logic        calc_enable,
  output logic        calc_reset,
  input  logic [31:0] calc_result,
  input  logic [31:0] calc_remainder,
  input  logic        calc_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [31:0] remainder,
  output logic        overflow,
  output logic        div_zero,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [15:0] MUL_LOAD = 16'(MUL_CYCLES - 1);
  localparam logic [15:0] ALU_LOAD = 16'(ALU_CYCLES - 1);

  state_t      state_r, next_s;
  logic [15:0] cnt_r;
  logic        accept_s;
  logic        dz_cmd_s;

  assign accept_s = in_ready && in_valid;

`ifdef CALC_SEQ_DIVZERO_EN
  logic dz_r;
  assign dz_cmd_s = (op_sel == 2'b11) && (op_b == 32'd0);
`else
  assign dz_cmd_s = 1'b0;
  assign div_zero = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_s = dz_cmd_s ? CAPTURE : ARM;
        end else begin
          next_s = IDLE;
        end
      end
      ARM: next_s = RUN;
      RUN: begin
        if (cnt_r == 16'd0) begin
          next_s = CAPTURE;
        end else begin
          next_s = RUN;
        end
      end
      CAPTURE: next_s = HOLD;
      HOLD: begin
        if (out_ready) begin
          next_s = IDLE;
        end else begin
          next_s = HOLD;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // run-length down-counter, loaded while ARM so RUN lasts exactly N cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 16'd0;
    end else if (state_r == ARM) begin
      cnt_r <= (calc_select == 2'b10) ? MUL_LOAD : ALU_LOAD;
    end else if ((state_r == RUN) && (cnt_r != 16'd0)) begin
      cnt_r <= cnt_r - 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // control outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      calc_enable <= 1'b0;
      calc_reset  <= 1'b1;
    end else begin
      in_ready    <= (next_s == IDLE);
      busy        <= (next_s != IDLE);
      out_valid   <= (next_s == HOLD);
      calc_enable <= (next_s == ARM) || (next_s == RUN);
      calc_reset  <= (next_s != RUN);
    end
  end

  // operand latch, frozen from accept until the return to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      calc_a      <= 32'd0;
      calc_b      <= 32'd0;
      calc_select <= 2'b00;
    end else if (accept_s) begin
      calc_a      <= op_a;
      calc_b      <= op_b;
      calc_select <= op_sel;
    end else begin
      calc_a      <= calc_a;
      calc_b      <= calc_b;
      calc_select <= calc_select;
    end
  end

`ifdef CALC_SEQ_DIVZERO_EN
  // divide-by-zero flag for the command in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dz_r <= 1'b0;
    end else if (accept_s) begin
      dz_r <= dz_cmd_s;
    end else begin
      dz_r <= dz_r;
    end
  end

  // result capture with the saturated divide-by-zero override
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= 32'd0;
      remainder <= 32'd0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else if ((state_r == CAPTURE) && dz_r) begin
      result    <= 32'hFFFF_FFFF;
      remainder <= calc_a;
      overflow  <= 1'b0;
      div_zero  <= 1'b1;
    end else if (state_r == CAPTURE) begin
      result    <= calc_result;
      remainder <= (calc_select == 2'b11) ? calc_remainder : 32'd0;
      overflow  <= (calc_select[1] == 1'b0) ? calc_overflow : 1'b0;
      div_zero  <= 1'b0;
    end else begin
      result    <= result;
      remainder <= remainder;
      overflow  <= overflow;
      div_zero  <= div_zero;
    end
  end
`else
  // result capture; the datapath output passes through unchanged for every op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= 32'd0;
      remainder <= 32'd0;
      overflow  <= 1'b0;
    end else if (state_r == CAPTURE) begin
      result    <= calc_result;
      remainder <= (calc_select == 2'b11) ? calc_remainder : 32'd0;
      overflow  <= (calc_select[1] == 1'b0) ? calc_overflow : 1'b0;
    end else begin
      result    <= result;
      remainder <= remainder;
      overflow  <= overflow;
    end
  end
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with a behavioural datapath model.
module tb_calc_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  op_sel;
  logic [31:0] calc_a;
  logic [31:0] calc_b;
  logic [1:0]  calc_select;
  logic        calc_enable;
  logic        calc_reset;
  logic [31:0] calc_result;
  logic [31:0] calc_remainder;
  logic        calc_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        overflow;
  logic        div_zero;
  logic        busy;

  int checks;
  int failures;
  logic en_seen;
  logic ov_seen;

  logic [63:0] prod_s;
  logic [32:0] sum_s;
  logic [32:0] diff_s;

  calc_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .calc_a(calc_a), .calc_b(calc_b), .calc_select(calc_select),
    .calc_enable(calc_enable), .calc_reset(calc_reset),
    .calc_result(calc_result), .calc_remainder(calc_remainder), .calc_overflow(calc_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .remainder(remainder), .overflow(overflow), .div_zero(div_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural datapath: carry/borrow as overflow, divide by zero gives a marker value
  always_comb begin
    prod_s         = {32'd0, calc_a} * {32'd0, calc_b};
    sum_s          = {1'b0, calc_a} + {1'b0, calc_b};
    diff_s         = {1'b0, calc_a} - {1'b0, calc_b};
    calc_result    = 32'd0;
    calc_remainder = 32'd0;
    calc_overflow  = 1'b0;
    case (calc_select)
      2'b00: begin calc_result = diff_s[31:0]; calc_overflow = diff_s[32]; end
      2'b01: begin calc_result = sum_s[31:0];  calc_overflow = sum_s[32];  end
      2'b10: begin calc_result = prod_s[31:0]; calc_overflow = |prod_s[63:32]; end
      default: begin
        if (calc_b == 32'd0) begin
          calc_result    = 32'h0BAD_0BAD;
          calc_remainder = calc_a;
          calc_overflow  = 1'b1;
        end else begin
          calc_result    = calc_a / calc_b;
          calc_remainder = calc_a % calc_b;
        end
      end
    endcase
  end

  always @(posedge clk) begin
    if (calc_enable) en_seen = 1'b1;
    if (out_valid)   ov_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] sel, input int elat, input logic [31:0] eres,
                        input logic [31:0] erem, input logic eov, input logic edz);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op_a = a; op_b = b; op_sel = sel; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = ~a; op_b = ~b; op_sel = ~sel;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_res"}, result, eres);
    check_eq({tag, "_rem"}, remainder, erem);
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eov});
    check_eq({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
    check_eq({tag, "_opa"}, calc_a, a);
    if (out_ready) begin
      @(posedge clk); #1;
      check_eq({tag, "_ovdrop"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    checks = 0; failures = 0; en_seen = 1'b0; ov_seen = 1'b0;
    reset = 1'b0; in_valid = 1'b0; op_a = 32'd0; op_b = 32'd0; op_sel = 2'b00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_en", {31'd0, calc_enable}, 32'd0);
    check_eq("rst_calc_reset", {31'd0, calc_reset}, 32'd1);
    check_eq("rst_result", result, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    do_cmd("mul", 32'd25, 32'd39, 2'b10, 37, 32'd975, 32'd0, 1'b0, 1'b0);
    do_cmd("add", 32'd200, 32'd100, 2'b01, 5, 32'd300, 32'd0, 1'b0, 1'b0);
    do_cmd("sub", 32'd75, 32'd25, 2'b00, 5, 32'd50, 32'd0, 1'b0, 1'b0);
    do_cmd("addov", 32'hFFFF_FFFF, 32'd2, 2'b01, 5, 32'd1, 32'd0, 1'b1, 1'b0);
    do_cmd("subbw", 32'd5, 32'd7, 2'b00, 5, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0);
    do_cmd("mulbig", 32'h0001_0000, 32'h0001_0000, 2'b10, 37, 32'd0, 32'd0, 1'b0, 1'b0);
    do_cmd("div", 32'd200, 32'd40, 2'b11, 5, 32'd5, 32'd0, 1'b0, 1'b0);
    do_cmd("divr", 32'd203, 32'd40, 2'b11, 5, 32'd5, 32'd3, 1'b0, 1'b0);

    en_seen = 1'b0;
`ifdef CALC_SEQ_DIVZERO_EN
    do_cmd("dz", 32'd7, 32'd0, 2'b11, 2, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b1);
    check_eq("dz_no_enable", {31'd0, en_seen}, 32'd0);
`else
    do_cmd("dz", 32'd7, 32'd0, 2'b11, 5, 32'h0BAD_0BAD, 32'd7, 1'b0, 1'b0);
    check_eq("dz_enable", {31'd0, en_seen}, 32'd1);
`endif

    // back-pressure in HOLD with an ignored command
    out_ready = 1'b0;
    do_cmd("bp", 32'd11, 32'd22, 2'b01, 5, 32'd33, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op_a = 32'd99; op_b = 32'd1; op_sel = 2'b10;
      @(posedge clk); #1;
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_result", result, 32'd33);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release", {31'd0, out_valid}, 32'd0);
    check_eq("bp_idle_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_eq("bp_no_queue", {31'd0, busy}, 32'd0);

    // abort a multiply in its tenth RUN cycle
    op_a = 32'd3; op_b = 32'd4; op_sel = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("ab_running", {31'd0, calc_enable}, 32'd1);
    ov_seen = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("ab_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("ab_busy", {31'd0, busy}, 32'd0);
    check_eq("ab_en", {31'd0, calc_enable}, 32'd0);
    check_eq("ab_calc_reset", {31'd0, calc_reset}, 32'd1);
    check_eq("ab_calc_a", calc_a, 32'd0);
    check_eq("ab_select", {30'd0, calc_select}, 32'd0);
    check_eq("ab_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("ab_result", result, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("ab_no_pulse", {31'd0, ov_seen}, 32'd0);
    do_cmd("post", 32'd1, 32'd2, 2'b01, 5, 32'd3, 32'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 34: cycles calc_reset is held low during a multiply before the result is captured.
REQ-002 Parameter ALU_CYCLES, default 2: settle cycles for add/subtract/divide before the result is captured; legal range 1-255.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1 / in_ready  output  1  command handshake.
REQ-006 op_a, op_b  input  32  operands / op_sel  input  2  operation (00 sub, 01 add, 10 mul, 11 div).
REQ-007 calc_a, calc_b  output  32 / calc_select  output  2  drive the datapath operand and select inputs.
REQ-008 calc_enable, calc_reset  output  1  drive the multiplier enable and its active-high start reset.
REQ-009 calc_result, calc_remainder  input  32 / calc_overflow  input  1  datapath results.
REQ-010 out_valid  output  1 / out_ready  input  1  result handshake.
REQ-011 result, remainder  output  32 / overflow, div_zero  output  1  registered results.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL use the states IDLE, ARM, RUN, CAPTURE and HOLD.
REQ-014 in_ready SHALL be high only in IDLE; a command is accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-015 On acceptance, op_a, op_b and op_sel SHALL be registered onto calc_a, calc_b and calc_select, which stay stable until the FSM returns to IDLE.
REQ-016 ARM (one cycle): calc_enable=1, calc_reset=1; the next state is RUN.
REQ-017 RUN: calc_reset=0, calc_enable=1, and a down-counter loads MUL_CYCLES-1 for op 10 or ALU_CYCLES-1 for any other op.
REQ-018 RUN SHALL exit to CAPTURE on the cycle the counter equals 0, so the run length is exactly MUL_CYCLES or ALU_CYCLES cycles.
REQ-019 CAPTURE (one cycle): result<=calc_result; remainder<=calc_remainder for op 11, else 0; overflow<=calc_overflow for op 00/01, else 0.
REQ-020 CAPTURE SHALL proceed to HOLD, where out_valid=1 and result, remainder, overflow and div_zero are held stable.
REQ-021 HOLD SHALL go to IDLE on the edge where out_ready=1; out_valid deasserts in that same transition.
REQ-022 Latency from accept edge to first out_valid SHALL be 3+MUL_CYCLES cycles for mul and 3+ALU_CYCLES cycles otherwise.
REQ-023 in_valid while busy SHALL be ignored (no queueing); operand changes on op_a/op_b after acceptance SHALL NOT affect calc_a/calc_b.
REQ-024 out_ready high before HOLD SHALL have no effect; out_ready may stay high continuously, giving one cycle of out_valid per command.
REQ-025 Outside ARM/RUN, calc_enable SHALL be 0 and calc_reset SHALL be 1, keeping the multiplier parked.

Reset
REQ-026 reset low SHALL immediately force state IDLE, counter 0, and in_ready=1.
REQ-027 reset low SHALL immediately force out_valid=0, busy=0, calc_enable=0, calc_reset=1.
REQ-028 reset low SHALL immediately clear calc_a, calc_b, calc_select, result, remainder, overflow and div_zero to 0.
REQ-029 reset asserted mid-operation SHALL abort the command with no out_valid pulse; the first command after release starts from IDLE normally.

Configuration
REQ-030 Macro CALC_SEQ_DIVZERO_EN defined: an accepted op 11 with op_b==0 SHALL skip ARM and RUN and enter CAPTURE next cycle.
REQ-031 In that divide-by-zero case: result=32'hFFFF_FFFF, remainder=op_a, div_zero=1, giving a latency of 2 cycles.
REQ-032 Macro undefined: div_zero SHALL be tied 0 and divide-by-zero SHALL follow the normal divide path, with calc_result passed through unchanged.

Verification
REQ-033 Mul: op_a=25, op_b=39, op_sel=10, out_ready=1 -> result=975, out_valid exactly 37 cycles after accept (default MUL_CYCLES).
REQ-034 Add/sub: 200+100 (01) -> 300, overflow=0; 75-25 (00) -> 50; out_valid 5 cycles after accept.
REQ-035 Div: 200/40 (11) -> result=5, remainder=0; 203/40 -> result=5, remainder=3.
REQ-036 Back-pressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid and result stable, in_ready=0, and a new in_valid is ignored.
REQ-037 Abort: assert reset in RUN cycle 10 of a mul -> all outputs at reset values at once, no out_valid; a following add completes correctly.
REQ-038 With CALC_SEQ_DIVZERO_EN: 7/0 -> result=FFFF_FFFF, remainder=7, div_zero=1, out_valid 2 cycles after accept, calc_enable never high.
